// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues in-order imem reads for the PC stream,
// tags returning data with its PC, and buffers results for decode.
module instr_fetch_queue #(
   parameter int unsigned PC_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PC_WIDTH-1:0]   pc_in,
   input  logic                  pc_valid,
   output logic                  pc_ready,
   input  logic                  flush,
   output logic                  imem_req,
   output logic [PC_WIDTH-1:0]   imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_data,
   output logic [PC_WIDTH-1:0]   instr_pc
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = CW + 1;

   // Tag FIFO: PCs of requests granted but not yet answered
   logic [PC_WIDTH-1:0]   tag_mem [DEPTH];
   logic [AW-1:0]         tag_wptr;
   logic [AW-1:0]         tag_rptr;

   // Output FIFO: {pc, data} pairs waiting for decode
   logic [PC_WIDTH-1:0]   out_pc_mem   [DEPTH];
   logic [DATA_WIDTH-1:0] out_data_mem [DEPTH];
   logic [AW-1:0]         out_wptr;
   logic [AW-1:0]         out_rptr;

   logic [CW-1:0]         outstanding;
   logic [CW-1:0]         out_count;
   logic [CW-1:0]         drop;

   logic                  credit;
   logic                  grant;
   logic                  resp;
   logic                  discard;
   logic                  out_wr;
   logic                  out_pop;

   // The two top PC bits fall off the word-to-byte address shift
   logic                  unused_pc_msbs;
   assign unused_pc_msbs = ^pc_in[PC_WIDTH-1:PC_WIDTH-2];

   assign imem_addr   = {pc_in[PC_WIDTH-3:0], 2'b00};
   assign instr_valid = (out_count != '0);
   assign instr_pc    = out_pc_mem[out_rptr];
   assign instr_data  = out_data_mem[out_rptr];
   assign pc_ready    = grant;

   // Request gating and per-cycle event decode; credit uses start-of-cycle counts
   always_comb begin
      credit   = (SW'(outstanding) + SW'(out_count)) < SW'(DEPTH);
      imem_req = pc_valid & credit & ~flush & ~reset;
      grant    = imem_req & imem_gnt;
      resp     = imem_rvalid & (outstanding != '0);
      discard  = (drop != '0) | flush;
      out_wr   = resp & ~discard;
      out_pop  = instr_valid & instr_ready;
   end

   // Tag storage write on grant
   always_ff @(posedge clk) begin
      if (grant) begin
         tag_mem[tag_wptr] <= pc_in;
      end
   end

   // Output storage write on an accepted response
   always_ff @(posedge clk) begin
      if (out_wr) begin
         out_pc_mem[out_wptr]   <= tag_mem[tag_rptr];
         out_data_mem[out_wptr] <= imem_rdata;
      end
   end

   // Pointers and counters; flush empties the output FIFO and converts in-flight to drops
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_wptr    <= '0;
         tag_rptr    <= '0;
         out_wptr    <= '0;
         out_rptr    <= '0;
         outstanding <= '0;
         out_count   <= '0;
         drop        <= '0;
      end else begin
         if (grant) begin
            tag_wptr <= tag_wptr + AW'(1);
         end
         if (resp) begin
            tag_rptr <= tag_rptr + AW'(1);
         end
         outstanding <= outstanding + CW'(grant) - CW'(resp);

         if (flush) begin
            drop <= drop + outstanding - CW'(resp);
         end else if (resp && (drop != '0)) begin
            drop <= drop - CW'(1);
         end

         if (flush) begin
            out_wptr  <= '0;
            out_rptr  <= '0;
            out_count <= '0;
         end else begin
            if (out_wr) begin
               out_wptr <= out_wptr + AW'(1);
            end
            if (out_pop) begin
               out_rptr <= out_rptr + AW'(1);
            end
            out_count <= out_count + CW'(out_wr) - CW'(out_pop);
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table plus memory-model sequences.
module tb_instr_fetch_queue;

   localparam int unsigned PW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [PW-1:0] pc_in;
   logic          pc_valid;
   logic          pc_ready;
   logic          flush;
   logic          imem_req;
   logic [PW-1:0] imem_addr;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [DW-1:0] imem_rdata;
   logic          instr_valid;
   logic          instr_ready;
   logic [DW-1:0] instr_data;
   logic [PW-1:0] instr_pc;

   instr_fetch_queue #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
      .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst, pv;
      logic [31:0]   pc;
      logic          fl, gnt, rv;
      logic [31:0]   rd;
      logic          rdy;
      logic          e_req, e_prdy, e_iv;
      logic [31:0]   e_pc, e_data;
   } vec_t;

   typedef struct {
      int unsigned   due;
      logic [31:0]   data;
   } rsp_t;

   vec_t          vt[$];
   rsp_t          pend[$];
   logic [31:0]   exp_q[$];

   int            checks = 0;
   int            errors = 0;
   int unsigned   cyc = 0;
   int unsigned   lat = 1;
   bit            auto_mem = 1'b0;
   logic [31:0]   next_pc;

   logic          obs_req, obs_prdy, obs_iv, obs_grant;
   logic [31:0]   obs_ipc, obs_idata, obs_addr;
   int            n_pop;
   logic [31:0]   first_pop_pc;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic addv(input logic rst, input logic pv, input logic [31:0] pc, input logic fl,
                       input logic gnt, input logic rv, input logic [31:0] rd, input logic rdy,
                       input logic e_req, input logic e_prdy, input logic e_iv,
                       input logic [31:0] e_pc, input logic [31:0] e_data);
      vec_t v;
      v.rst = rst; v.pv = pv; v.pc = pc; v.fl = fl; v.gnt = gnt; v.rv = rv; v.rd = rd;
      v.rdy = rdy; v.e_req = e_req; v.e_prdy = e_prdy; v.e_iv = e_iv;
      v.e_pc = e_pc; v.e_data = e_data;
      vt.push_back(v);
   endtask

   // One clock: memory model drives response, sample outputs, scoreboard, advance
   task automatic cycle();
      bit   grant;
      bit   pop;
      rsp_t r;
      if (auto_mem) begin
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].data;
         end
      end
      #1;
      obs_req   = imem_req;
      obs_prdy  = pc_ready;
      obs_iv    = instr_valid;
      obs_ipc   = instr_pc;
      obs_idata = instr_data;
      obs_addr  = imem_addr;
      grant     = imem_req & imem_gnt;
      pop       = instr_valid & instr_ready;
      obs_grant = grant;
      if (auto_mem) begin
         if (imem_req) chk32("addr", imem_addr, {pc_in[PW-3:0], 2'b00});
         if (pop) begin
            if (n_pop == 0) first_pop_pc = instr_pc;
            n_pop++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop: got pc %h expected no entry", instr_pc);
            end else begin
               chk32("deliv_pc", instr_pc, exp_q[0]);
               chk32("deliv_data", instr_data, 32'hA000_0000 + exp_q[0]);
               void'(exp_q.pop_front());
            end
         end
         if (grant) exp_q.push_back(pc_in);
         if (flush || reset) exp_q.delete();
         checks++;
         if (exp_q.size() > DEPTH) begin
            errors++;
            $display("FAIL occupancy: got %0d expected <= %0d", exp_q.size(), DEPTH);
         end
      end
      @(posedge clk);
      if (auto_mem) begin
         if (imem_rvalid) void'(pend.pop_front());
         if (grant) begin
            r.due  = cyc + lat;
            r.data = 32'hA000_0000 + pc_in;
            pend.push_back(r);
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1; pc_valid = 1'b0; flush = 1'b0; imem_gnt = 1'b0;
      instr_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      cycle();
      reset = 1'b0;
      pend.delete();
      exp_q.delete();
      n_pop = 0;
   endtask

   // Free-running PC step: present next_pc, advance it when consumed
   task automatic pc_step();
      pc_in = next_pc;
      cycle();
      if (obs_grant) next_pc = next_pc + 1;
   endtask

   initial begin
      reset = 1'b1; pc_in = '0; pc_valid = 1'b0; flush = 1'b0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
      n_pop = 0; first_pop_pc = '0; next_pc = '0;
      @(negedge clk);

      // ---------------- directed vector table ----------------
      //   rst   pv    pc  fl    gnt   rv    rdata          rdy   req   prdy  iv    ipc  idata
      addv(1'b1,1'b1, 0, 1'b0,1'b1,1'b0, 32'h0,         1'b0, 1'b0,1'b0,1'b0, 0,  32'h0);
      addv(1'b0,1'b1, 0, 1'b0,1'b1,1'b0, 32'h0,         1'b0, 1'b1,1'b1,1'b0, 0,  32'h0);
      addv(1'b0,1'b1, 1, 1'b0,1'b1,1'b1, 32'hA000_0000, 1'b0, 1'b1,1'b1,1'b0, 0,  32'h0);
      addv(1'b0,1'b1, 2, 1'b0,1'b0,1'b1, 32'hA000_0001, 1'b0, 1'b1,1'b0,1'b1, 0,  32'hA000_0000);
      addv(1'b0,1'b1, 2, 1'b0,1'b1,1'b0, 32'h0,         1'b1, 1'b1,1'b1,1'b1, 0,  32'hA000_0000);
      addv(1'b0,1'b1, 3, 1'b0,1'b1,1'b1, 32'hA000_0002, 1'b1, 1'b1,1'b1,1'b1, 1,  32'hA000_0001);
      addv(1'b0,1'b1, 4, 1'b1,1'b0,1'b0, 32'h0,         1'b0, 1'b0,1'b0,1'b1, 2,  32'hA000_0002);
      addv(1'b0,1'b1, 4, 1'b0,1'b1,1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1,1'b1,1'b0, 0,  32'h0);
      addv(1'b0,1'b1, 5, 1'b0,1'b0,1'b1, 32'hA000_0004, 1'b0, 1'b1,1'b0,1'b0, 0,  32'h0);
      addv(1'b0,1'b1, 5, 1'b0,1'b0,1'b1, 32'h0BAD_0BAD, 1'b0, 1'b1,1'b0,1'b1, 4,  32'hA000_0004);
      addv(1'b0,1'b1, 5, 1'b0,1'b0,1'b0, 32'h0,         1'b1, 1'b1,1'b0,1'b1, 4,  32'hA000_0004);
      addv(1'b0,1'b1, 5, 1'b0,1'b0,1'b0, 32'h0,         1'b0, 1'b1,1'b0,1'b0, 0,  32'h0);

      auto_mem = 1'b0;
      do_reset();
      for (int i = 0; i < vt.size(); i++) begin
         reset = vt[i].rst; pc_valid = vt[i].pv; pc_in = vt[i].pc; flush = vt[i].fl;
         imem_gnt = vt[i].gnt; imem_rvalid = vt[i].rv; imem_rdata = vt[i].rd;
         instr_ready = vt[i].rdy;
         cycle();
         chk1($sformatf("v%0d_req", i), obs_req, vt[i].e_req);
         chk1($sformatf("v%0d_pc_ready", i), obs_prdy, vt[i].e_prdy);
         chk1($sformatf("v%0d_instr_valid", i), obs_iv, vt[i].e_iv);
         chk32($sformatf("v%0d_addr", i), obs_addr, {vt[i].pc[29:0], 2'b00});
         if (vt[i].e_iv) begin
            chk32($sformatf("v%0d_instr_pc", i), obs_ipc, vt[i].e_pc);
            chk32($sformatf("v%0d_instr_data", i), obs_idata, vt[i].e_data);
         end
      end

      auto_mem = 1'b1;

      // ---------------- streaming ----------------
      do_reset();
      lat = 1; imem_gnt = 1'b1; instr_ready = 1'b1; pc_valid = 1'b1; next_pc = 0;
      for (int i = 0; i < 20; i++) begin
         pc_step();
         chk1($sformatf("stream_valid_c%0d", i), obs_iv, (i >= 2));
      end
      chk32("stream_grants", next_pc, 32'd20);
      chk32("stream_pops", 32'(n_pop), 32'd18);

      // ---------------- decode stall ----------------
      do_reset();
      lat = 1; imem_gnt = 1'b1; instr_ready = 1'b0; pc_valid = 1'b1; next_pc = 0;
      for (int i = 0; i < 10; i++) begin
         pc_step();
         if (i >= 5) begin
            chk1("stall_req_low", obs_req, 1'b0);
            chk1("stall_pc_ready_low", obs_prdy, 1'b0);
            chk1("stall_full_valid", obs_iv, 1'b1);
            chk32("stall_head_pc", obs_ipc, 32'd0);
         end
      end
      chk32("stall_fetched", next_pc, 32'd4);
      instr_ready = 1'b1;
      for (int i = 0; i < 10; i++) pc_step();
      chk32("stall_first_drained", first_pop_pc, 32'd0);
      chk1("stall_resumed", (next_pc > 32'd4), 1'b1);

      // ---------------- grant stall ----------------
      do_reset();
      lat = 1; imem_gnt = 1'b0; instr_ready = 1'b1; pc_valid = 1'b1; next_pc = 5;
      for (int i = 0; i < 3; i++) begin
         pc_step();
         chk1("gstall_req", obs_req, 1'b1);
         chk1("gstall_pc_ready", obs_prdy, 1'b0);
      end
      imem_gnt = 1'b1;
      pc_step();
      chk1("gstall_granted", obs_prdy, 1'b1);
      pc_valid = 1'b0;
      for (int i = 0; i < 4; i++) pc_step();
      chk32("gstall_pops", 32'(n_pop), 32'd1);
      chk32("gstall_pc", first_pop_pc, 32'd5);

      // ---------------- flush with in-flight ----------------
      do_reset();
      lat = 3; imem_gnt = 1'b1; instr_ready = 1'b0; pc_valid = 1'b1; next_pc = 10;
      for (int i = 0; i < 4; i++) pc_step();
      flush = 1'b1;
      pc_step();
      chk1("flush_pre_valid", obs_iv, 1'b1);
      chk32("flush_pre_pc", obs_ipc, 32'd10);
      chk1("flush_no_req", obs_req, 1'b0);
      flush = 1'b0; next_pc = 20; instr_ready = 1'b1;
      pc_step();
      chk1("flush_post_valid", obs_iv, 1'b0);
      for (int i = 0; i < 12; i++) pc_step();
      chk1("flush_delivered", (n_pop > 0), 1'b1);
      chk32("flush_first_pc", first_pop_pc, 32'd20);

      // ---------------- random grant/ready with mixed latency ----------------
      do_reset();
      pc_valid = 1'b1; next_pc = 100;
      for (int i = 0; i < 60; i++) begin
         imem_gnt    = 1'($urandom_range(0, 1));
         instr_ready = 1'($urandom_range(0, 1));
         lat         = $urandom_range(1, 3);
         pc_step();
      end
      pc_valid = 1'b0; instr_ready = 1'b1; imem_gnt = 1'b0;
      for (int i = 0; i < 12; i++) pc_step();
      chk32("rand_all_delivered", 32'(exp_q.size()), 32'd0);
      chk32("rand_count", 32'(n_pop), next_pc - 32'd100);

      // ---------------- reset mid-stream ----------------
      do_reset();
      lat = 2; imem_gnt = 1'b1; instr_ready = 1'b0; pc_valid = 1'b1; next_pc = 30;
      for (int i = 0; i < 4; i++) pc_step();
      reset = 1'b1;
      pc_step();
      chk1("rst_req_during", obs_req, 1'b0);
      chk1("rst_pre_valid", obs_iv, 1'b1);
      reset = 1'b0; pc_valid = 1'b0;
      pc_step();
      chk1("rst_valid", obs_iv, 1'b0);
      chk1("rst_req", obs_req, 1'b0);
      chk1("rst_pc_ready", obs_prdy, 1'b0);
      pc_step();
      chk1("rst_stale_ignored", obs_iv, 1'b0);
      pc_step();
      chk1("rst_stale_ignored2", obs_iv, 1'b0);
      chk32("rst_model_drained", 32'(pend.size()), 32'd0);
      n_pop = 0; lat = 1; pc_valid = 1'b1; instr_ready = 1'b1; next_pc = 40;
      for (int i = 0; i < 8; i++) pc_step();
      chk32("rst_first_pc", first_pop_pc, 32'd40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
